cursor_controller: RTL and testbench

Turns the five raw board push-buttons into a registered absolute cursor position on a parametrised cell grid. Each button is synchronised and debounced. Each debounced press moves the cursor one cell. Holding a direction auto-repeats after a delay. The block sits between the board button pins and the game core, and drives the cursor cell index and its pixel origin.

---
 rtl/cursor_pkg.sv | 29 ++
 rtl/button_debounce.sv | 58 +++++
 rtl/cursor_controller.sv | 174 +++++++++++++++++
 tb/tb_cursor_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared encodings for the cursor controller: step direction, repeat-FSM states
// and the button index map used by the top level.
package cursor_pkg;

    typedef enum logic [1:0] {
        STEP_ZERO = 2'b00,
        STEP_POS  = 2'b01,
        STEP_NEG  = 2'b11
    } step_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } state_e;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    // Opposing buttons cancel to a zero step.
    function automatic step_e step_dir(input logic neg, input logic pos);
        if (neg && !pos)      return STEP_NEG;
        else if (pos && !neg) return STEP_POS;
        else                  return STEP_ZERO;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchroniser, stability-count debouncer and a
// registered rising-edge press pulse one cycle after the debounced level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
        // Counter only runs while the input disagrees; any agreement restarts it.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync2_q;
            else                   cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cursor_controller.sv
// Button-driven grid cursor: debounces five buttons, runs a shared press/auto-repeat
// FSM and keeps registered cell and pixel-origin coordinates.
module cursor_controller
    import cursor_pkg::*;
#(
    parameter int GRID_COLS       = 32,
    parameter int GRID_ROWS       = 24,
    parameter int CELL_SIZE       = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int WRAP            = 1,
    localparam int CW  = $clog2(GRID_COLS),
    localparam int RW  = $clog2(GRID_ROWS),
    localparam int PXW = $clog2(GRID_COLS * CELL_SIZE),
    localparam int PYW = $clog2(GRID_ROWS * CELL_SIZE)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           button_left,
    input  logic           button_right,
    input  logic           button_up,
    input  logic           button_down,
    input  logic           button_select,
    output logic [CW-1:0]  cur_col,
    output logic [RW-1:0]  cur_row,
    output logic [PXW-1:0] pix_x,
    output logic [PYW-1:0] pix_y,
    output logic           move_valid,
    output logic           select_pulse
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] COL_MAX    = CW'(GRID_COLS - 1);
    localparam logic [RW-1:0] ROW_MAX    = RW'(GRID_ROWS - 1);

    logic [3:0] dir_raw, dir_level, dir_press;
    logic       sel_press, sel_level_unused;

    assign dir_raw = {button_down, button_up, button_right, button_left};

    for (genvar i = 0; i < 4; i++) begin : g_dir
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (dir_raw[i]),
            .level (dir_level[i]),
            .press (dir_press[i])
        );
    end

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk   (clk),
        .rst   (rst),
        .raw   (button_select),
        .level (sel_level_unused),
        .press (sel_press)
    );

    step_e  step_x, step_y;
    logic   held, any_press, nonzero, do_step;
    state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    assign step_x    = step_dir(dir_level[BTN_LEFT], dir_level[BTN_RIGHT]);
    assign step_y    = step_dir(dir_level[BTN_UP],   dir_level[BTN_DOWN]);
    assign held      = |dir_level;
    assign any_press = |dir_press;
    assign nonzero   = (step_x != STEP_ZERO) || (step_y != STEP_ZERO);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        do_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (any_press && nonzero) begin
                    do_step = 1'b1;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!held) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (any_press) begin
                    do_step = 1'b1;
                    timer_d = '0;
                end else if (timer_q == DELAY_LAST) begin
                    do_step = 1'b1;
                    timer_d = '0;
                    state_d = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (!held) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (any_press) begin
                    // A new direction restarts the initial hold delay.
                    do_step = 1'b1;
                    timer_d = '0;
                    state_d = ST_DELAY;
                end else if (timer_q == RATE_LAST) begin
                    do_step = 1'b1;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [PXW-1:0] pix_x_q, pix_x_d;
    logic [PYW-1:0] pix_y_q, pix_y_d;
    logic           move_valid_q, move_valid_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (do_step) begin
            unique case (step_x)
                STEP_NEG: col_d = (col_q == '0) ? ((WRAP != 0) ? COL_MAX : '0) : col_q - CW'(1);
                STEP_POS: col_d = (col_q == COL_MAX) ? ((WRAP != 0) ? '0 : COL_MAX) : col_q + CW'(1);
                default:  col_d = col_q;
            endcase
            unique case (step_y)
                STEP_NEG: row_d = (row_q == '0) ? ((WRAP != 0) ? ROW_MAX : '0) : row_q - RW'(1);
                STEP_POS: row_d = (row_q == ROW_MAX) ? ((WRAP != 0) ? '0 : ROW_MAX) : row_q + RW'(1);
                default:  row_d = row_q;
            endcase
        end
        // Zero or saturated steps leave the position alone and stay silent.
        move_valid_d = (col_d != col_q) || (row_d != row_q);
        pix_x_d      = PXW'(col_d) * PXW'(CELL_SIZE);
        pix_y_d      = PYW'(row_d) * PYW'(CELL_SIZE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            move_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            move_valid_q <= move_valid_d;
        end
    end

    assign cur_col      = col_q;
    assign cur_row      = row_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign move_valid   = move_valid_q;
    assign select_pulse = sel_press;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller on an 8x6 grid with short debounce/repeat
// timing; a wrapping and a clamping instance are exercised.
module tb_cursor_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic b_left = 0, b_right = 0, b_up = 0, b_down = 0, b_sel = 0;
    logic c_left = 0, c_right = 0;
    logic [2:0] cur_col, cur_row, c_col, c_row;
    logic [7:0] pix_x, c_pix_x;
    logic [6:0] pix_y, c_pix_y;
    logic       move_valid, select_pulse, c_mv, c_sel;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int mv_q[$];
    int sel_q[$];
    int c_mv_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (move_valid)   mv_q.push_back(cyc);
        if (select_pulse) sel_q.push_back(cyc);
        if (c_mv)         c_mv_cnt++;
    end

    cursor_controller #(
        .GRID_COLS(8), .GRID_ROWS(6), .CELL_SIZE(20), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(1)
    ) dut (
        .clk(clk), .rst(rst),
        .button_left(b_left), .button_right(b_right), .button_up(b_up),
        .button_down(b_down), .button_select(b_sel),
        .cur_col(cur_col), .cur_row(cur_row), .pix_x(pix_x), .pix_y(pix_y),
        .move_valid(move_valid), .select_pulse(select_pulse)
    );

    cursor_controller #(
        .GRID_COLS(8), .GRID_ROWS(6), .CELL_SIZE(20), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(0)
    ) dut_clamp (
        .clk(clk), .rst(rst),
        .button_left(c_left), .button_right(c_right), .button_up(1'b0),
        .button_down(1'b0), .button_select(1'b0),
        .cur_col(c_col), .cur_row(c_row), .pix_x(c_pix_x), .pix_y(c_pix_y),
        .move_valid(c_mv), .select_pulse(c_sel)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(3);
        rst = 1'b0;
        vecs++; if (cur_col !== 3'd0) begin errs++; $display("FAIL reset_col: got %0d want 0", cur_col); end
        vecs++; if (cur_row !== 3'd0) begin errs++; $display("FAIL reset_row: got %0d want 0", cur_row); end
        vecs++; if (pix_x !== 8'd0) begin errs++; $display("FAIL reset_pix_x: got %0d want 0", pix_x); end
        vecs++; if (pix_y !== 7'd0) begin errs++; $display("FAIL reset_pix_y: got %0d want 0", pix_y); end
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL reset_mv: got %b want 0", move_valid); end
        vecs++; if (select_pulse !== 1'b0) begin errs++; $display("FAIL reset_sel: got %b want 0", select_pulse); end
    endtask

    task automatic test_bounce();
        int n0, a;
        n0 = mv_q.size();
        for (int i = 0; i < 15; i++) begin
            b_right = (i % 2 == 0);
            tick(1 + i % 3);
        end
        b_right = 0; tick(2);
        b_right = 1; a = cyc; tick(10);
        b_right = 0; tick(14);
        vecs++; if (mv_q.size() - n0 != 1) begin errs++; $display("FAIL bounce_count: got %0d want 1", mv_q.size() - n0); end
        vecs++; if (mv_q[n0] != a + 8) begin errs++; $display("FAIL bounce_latency: got %0d want %0d", mv_q[n0] - a, 8); end
        vecs++; if (cur_col !== 3'd1) begin errs++; $display("FAIL bounce_col: got %0d want 1", cur_col); end
        vecs++; if (pix_x !== 8'd20) begin errs++; $display("FAIL bounce_pix_x: got %0d want 20", pix_x); end
        vecs++; if (cur_row !== 3'd0) begin errs++; $display("FAIL bounce_row: got %0d want 0", cur_row); end
    endtask

    task automatic test_auto_repeat();
        int n0, a;
        int offs[5];
        offs = '{8, 28, 33, 38, 43};
        n0 = mv_q.size();
        b_down = 1; a = cyc; tick(38);
        b_down = 0; tick(20);
        vecs++; if (mv_q.size() - n0 != 5) begin errs++; $display("FAIL repeat_count: got %0d want 5", mv_q.size() - n0); end
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (mv_q[n0 + i] != a + offs[i]) begin
                errs++; $display("FAIL repeat_step%0d: got +%0d want +%0d", i, mv_q[n0 + i] - a, offs[i]);
            end
        end
        vecs++; if (cur_row !== 3'd5) begin errs++; $display("FAIL repeat_row: got %0d want 5", cur_row); end
        vecs++; if (pix_y !== 7'd100) begin errs++; $display("FAIL repeat_pix_y: got %0d want 100", pix_y); end
        vecs++; if (cur_col !== 3'd1) begin errs++; $display("FAIL repeat_col: got %0d want 1", cur_col); end
    endtask

    task automatic test_wrap_clamp();
        int n0, a;
        b_left = 1; tick(10); b_left = 0; tick(14);
        vecs++; if (cur_col !== 3'd0) begin errs++; $display("FAIL wrap_pre_col: got %0d want 0", cur_col); end
        n0 = mv_q.size();
        b_left = 1; a = cyc; tick(10); b_left = 0; tick(14);
        vecs++; if (mv_q.size() - n0 != 1 || mv_q[n0] != a + 8) begin
            errs++; $display("FAIL wrap_mv: got %0d pulses want 1 at +8", mv_q.size() - n0);
        end
        vecs++; if (cur_col !== 3'd7) begin errs++; $display("FAIL wrap_col: got %0d want 7", cur_col); end
        vecs++; if (pix_x !== 8'd140) begin errs++; $display("FAIL wrap_pix_x: got %0d want 140", pix_x); end
        c_left = 1; tick(10); c_left = 0; tick(14);
        vecs++; if (c_mv_cnt != 0) begin errs++; $display("FAIL clamp_mv: got %0d want 0", c_mv_cnt); end
        vecs++; if (c_col !== 3'd0) begin errs++; $display("FAIL clamp_col: got %0d want 0", c_col); end
        c_right = 1; tick(10); c_right = 0; tick(14);
        vecs++; if (c_mv_cnt != 1) begin errs++; $display("FAIL clamp_right_mv: got %0d want 1", c_mv_cnt); end
        vecs++; if (c_col !== 3'd1 || c_pix_x !== 8'd20) begin
            errs++; $display("FAIL clamp_right_pos: got col %0d pix %0d want 1 20", c_col, c_pix_x);
        end
        vecs++; if (c_row !== 3'd0 || c_pix_y !== 7'd0 || c_sel !== 1'b0) begin
            errs++; $display("FAIL clamp_idle_outs: got row %0d pix_y %0d sel %b want 0 0 0", c_row, c_pix_y, c_sel);
        end
    endtask

    task automatic test_opposing_diagonal();
        int n0, a;
        n0 = mv_q.size();
        b_left = 1; b_right = 1; tick(10);
        b_left = 0; b_right = 0; tick(14);
        vecs++; if (mv_q.size() != n0) begin errs++; $display("FAIL opposing_mv: got %0d want 0", mv_q.size() - n0); end
        vecs++; if (cur_col !== 3'd7) begin errs++; $display("FAIL opposing_col: got %0d want 7", cur_col); end
        rst = 1; tick(1); rst = 0; tick(2);
        n0 = mv_q.size();
        b_up = 1; b_right = 1; a = cyc; tick(10);
        b_up = 0; b_right = 0; tick(14);
        vecs++; if (mv_q.size() - n0 != 1 || mv_q[n0] != a + 8) begin
            errs++; $display("FAIL diag_mv: got %0d pulses want 1 at +8", mv_q.size() - n0);
        end
        vecs++; if (cur_col !== 3'd1 || cur_row !== 3'd5) begin
            errs++; $display("FAIL diag_pos: got (%0d,%0d) want (1,5)", cur_col, cur_row);
        end
        vecs++; if (pix_x !== 8'd20 || pix_y !== 7'd100) begin
            errs++; $display("FAIL diag_pix: got (%0d,%0d) want (20,100)", pix_x, pix_y);
        end
    endtask

    task automatic test_select();
        int n0, s0, a;
        n0 = mv_q.size(); s0 = sel_q.size();
        b_sel = 1; a = cyc; tick(100); b_sel = 0; tick(14);
        vecs++; if (sel_q.size() - s0 != 1) begin errs++; $display("FAIL sel_hold_count: got %0d want 1", sel_q.size() - s0); end
        vecs++; if (sel_q[s0] != a + 7) begin errs++; $display("FAIL sel_latency: got +%0d want +7", sel_q[s0] - a); end
        vecs++; if (mv_q.size() != n0) begin errs++; $display("FAIL sel_no_move: got %0d want 0", mv_q.size() - n0); end
        s0 = sel_q.size();
        b_sel = 1; b_down = 1; a = cyc; tick(10);
        b_sel = 0; b_down = 0; tick(14);
        vecs++; if (sel_q.size() - s0 != 1 || sel_q[s0] != a + 7) begin
            errs++; $display("FAIL sel_combo_sel: got %0d pulses want 1 at +7", sel_q.size() - s0);
        end
        vecs++; if (mv_q.size() - n0 != 1 || mv_q[n0] != a + 8) begin
            errs++; $display("FAIL sel_combo_mv: got %0d pulses want 1 at +8", mv_q.size() - n0);
        end
        vecs++; if (cur_row !== 3'd0 || cur_col !== 3'd1) begin
            errs++; $display("FAIL sel_combo_pos: got (%0d,%0d) want (1,0)", cur_col, cur_row);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n0, n1, a, e;
        n0 = mv_q.size();
        b_right = 1; a = cyc; tick(30);
        vecs++; if (mv_q.size() - n0 != 2 || mv_q[n0 + 1] != a + 28) begin
            errs++; $display("FAIL rmh_pre_steps: got %0d want 2 by +28", mv_q.size() - n0);
        end
        vecs++; if (cur_col !== 3'd3) begin errs++; $display("FAIL rmh_pre_col: got %0d want 3", cur_col); end
        rst = 1; tick(1); rst = 0; e = cyc;
        vecs++; if (cur_col !== 3'd0 || cur_row !== 3'd0) begin
            errs++; $display("FAIL rmh_pos: got (%0d,%0d) want (0,0)", cur_col, cur_row);
        end
        vecs++; if (pix_x !== 8'd0 || pix_y !== 7'd0) begin
            errs++; $display("FAIL rmh_pix: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        vecs++; if (move_valid !== 1'b0 || select_pulse !== 1'b0) begin
            errs++; $display("FAIL rmh_pulses: got mv %b sel %b want 0 0", move_valid, select_pulse);
        end
        n1 = mv_q.size();
        tick(12);
        vecs++; if (mv_q.size() - n1 != 1 || mv_q[n1] != e + 8) begin
            errs++; $display("FAIL rmh_fresh_press: got %0d pulses first at +%0d want 1 at +8", mv_q.size() - n1, mv_q[n1] - e);
        end
        vecs++; if (cur_col !== 3'd1) begin errs++; $display("FAIL rmh_col: got %0d want 1", cur_col); end
        b_right = 0; tick(14);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_auto_repeat();
        test_wrap_clamp();
        test_opposing_diagonal();
        test_select();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
